router_vc_fifo: RTL and testbench

Single-clock, multi-channel entry FIFO for the router datapath. It holds NUM_VC independent virtual-channel queues, each DEPTH entries of WIDTH units, behind one shared unit-serial write port and one shared unit-addressed read port. An entry becomes visible to the reader only when the writer commits it. It sits between the input port parser and the crossbar arbiter, which needs per-VC occupancy, almost-full and error indication.

---
 rtl/router_vc_fifo.sv | 114 +++++++++++
 tb/tb_router_vc_fifo.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/router_vc_fifo.sv
// router_vc_fifo: multi-VC entry FIFO between the input port parser and the
// crossbar arbiter. Each VC holds DEPTH entries of WIDTH units. The writer fills
// the open entry unit by unit and commits it. The reader addresses units inside
// the head entry and pops it when done. Occupancy flags are decoded from the
// per-VC wrap-bit pointers.
module router_vc_fifo #(
  parameter int NUM_VC    = 2,
  parameter int VC_SZ     = 1,
  parameter int DEPTH     = 4,
  parameter int PTR_SZ    = 2,
  parameter int WIDTH     = 11,
  parameter int UWIDTH    = 8,
  parameter int PTR_IN_SZ = 4,
  parameter int AFULL_TH  = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [VC_SZ-1:0]             wvc,
  input  logic                         wr_en,
  input  logic [PTR_IN_SZ-1:0]         waddr_in,
  input  logic [UWIDTH-1:0]            wdata,
  input  logic                         wcommit,
  input  logic [VC_SZ-1:0]             rvc,
  input  logic [PTR_IN_SZ-1:0]         raddr_in,
  input  logic                         rinc,
  output logic [UWIDTH-1:0]            rdata,
  output logic [NUM_VC-1:0]            wfull,
  output logic [NUM_VC-1:0]            rempty,
  output logic [NUM_VC-1:0]            afull,
  output logic [NUM_VC*(PTR_SZ+1)-1:0] count,
  output logic                         ovf,
  output logic                         udf
);

  localparam int CW = PTR_SZ + 1;
  localparam logic [CW-1:0] PTR_ONE = CW'(1);
  localparam logic [CW-1:0] AFULL_CMP = CW'(AFULL_TH);
  localparam logic [PTR_IN_SZ:0] WIDTH_CMP = (PTR_IN_SZ + 1)'(WIDTH);

  // Per-VC pointers: low PTR_SZ bits select the slot, MSB is the wrap bit
  logic [CW-1:0] wptr [NUM_VC];
  logic [CW-1:0] rptr [NUM_VC];
  logic [CW-1:0] vc_count [NUM_VC];

  // Entry storage, deliberately left without reset
  logic [UWIDTH-1:0] mem [NUM_VC][DEPTH][WIDTH];

  logic waddr_ok;
  logic raddr_ok;
  logic wr_ok;
  logic wcommit_ok;
  logic rinc_ok;
  logic ovf_next;
  logic udf_next;

  // Occupancy decode, purely from the registered pointers
  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc_flags
    assign vc_count[g] = wptr[g] - rptr[g];
    assign rempty[g]   = (wptr[g] == rptr[g]);
    assign wfull[g]    = (wptr[g][PTR_SZ] != rptr[g][PTR_SZ]) &&
                         (wptr[g][PTR_SZ-1:0] == rptr[g][PTR_SZ-1:0]);
    assign afull[g]    = (vc_count[g] >= AFULL_CMP);
    assign count[g*CW +: CW] = vc_count[g];
  end

  assign waddr_ok = ({1'b0, waddr_in} < WIDTH_CMP);
  assign raddr_ok = ({1'b0, raddr_in} < WIDTH_CMP);

  // Full/empty checks use pre-edge state, so a same-cycle pop never frees room
  // for a write or commit on the same VC.
  assign wr_ok      = wr_en && !wfull[wvc] && waddr_ok;
  assign wcommit_ok = wcommit && !wfull[wvc];
  assign rinc_ok    = rinc && !rempty[rvc];
  assign ovf_next   = (wr_en || wcommit) && wfull[wvc];
  assign udf_next   = rinc && rempty[rvc];

  // Pointer advance on accepted commit and pop; reset discards every entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_VC; k++) begin
        wptr[k] <= '0;
        rptr[k] <= '0;
      end
    end else begin
      if (wcommit_ok) begin
        wptr[wvc] <= wptr[wvc] + PTR_ONE;
      end
      if (rinc_ok) begin
        rptr[rvc] <= rptr[rvc] + PTR_ONE;
      end
    end
  end

  // Unit write into the open slot of the selected VC
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) begin
      mem[wvc][wptr[wvc][PTR_SZ-1:0]][waddr_in] <= wdata;
    end
  end

  // Registered read of the head entry plus the one-cycle error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      rdata <= raddr_ok ? mem[rvc][rptr[rvc][PTR_SZ-1:0]][raddr_in] : '0;
      ovf   <= ovf_next;
      udf   <= udf_next;
    end
  end

endmodule

// File: tb/tb_router_vc_fifo.sv
// tb_router_vc_fifo: directed test of router_vc_fifo with hand-computed
// expected values for fill, overflow, ordered read, simultaneous commit/pop,
// pointer wrap and mid-operation reset.
module tb_router_vc_fifo;

  localparam int NUM_VC    = 2;
  localparam int VC_SZ     = 1;
  localparam int DEPTH     = 4;
  localparam int PTR_SZ    = 2;
  localparam int WIDTH     = 11;
  localparam int UWIDTH    = 8;
  localparam int PTR_IN_SZ = 4;
  localparam int AFULL_TH  = 3;

  logic                         clk;
  logic                         rst;
  logic [VC_SZ-1:0]             wvc;
  logic                         wr_en;
  logic [PTR_IN_SZ-1:0]         waddr_in;
  logic [UWIDTH-1:0]            wdata;
  logic                         wcommit;
  logic [VC_SZ-1:0]             rvc;
  logic [PTR_IN_SZ-1:0]         raddr_in;
  logic                         rinc;
  logic [UWIDTH-1:0]            rdata;
  logic [NUM_VC-1:0]            wfull;
  logic [NUM_VC-1:0]            rempty;
  logic [NUM_VC-1:0]            afull;
  logic [NUM_VC*(PTR_SZ+1)-1:0] count;
  logic                         ovf;
  logic                         udf;

  logic [2:0] cnt0;
  logic [2:0] cnt1;

  int assertCount = 0;
  int failCount   = 0;

  assign cnt0 = count[2:0];
  assign cnt1 = count[5:3];

  router_vc_fifo #(
    .NUM_VC(NUM_VC), .VC_SZ(VC_SZ), .DEPTH(DEPTH), .PTR_SZ(PTR_SZ),
    .WIDTH(WIDTH), .UWIDTH(UWIDTH), .PTR_IN_SZ(PTR_IN_SZ), .AFULL_TH(AFULL_TH)
  ) dut (
    .clk(clk), .rst(rst), .wvc(wvc), .wr_en(wr_en), .waddr_in(waddr_in),
    .wdata(wdata), .wcommit(wcommit), .rvc(rvc), .raddr_in(raddr_in),
    .rinc(rinc), .rdata(rdata), .wfull(wfull), .rempty(rempty),
    .afull(afull), .count(count), .ovf(ovf), .udf(udf)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
      else begin
        failCount++;
        $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge
  task automatic applyStimulus(input logic s_wvc, input logic s_wr_en,
                               input logic [3:0] s_waddr, input logic [7:0] s_wdata,
                               input logic s_wcommit, input logic s_rvc,
                               input logic [3:0] s_raddr, input logic s_rinc);
    wvc      = s_wvc;
    wr_en    = s_wr_en;
    waddr_in = s_waddr;
    wdata    = s_wdata;
    wcommit  = s_wcommit;
    rvc      = s_rvc;
    raddr_in = s_raddr;
    rinc     = s_rinc;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    wvc = '0; wr_en = 1'b0; waddr_in = '0; wdata = '0; wcommit = 1'b0;
    rvc = '0; raddr_in = '0; rinc = 1'b0;

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_rdata", rdata, 32'h0);
    checkOutput("rst_rempty", rempty, 32'h3);
    checkOutput("rst_wfull", wfull, 32'h0);
    checkOutput("rst_afull", afull, 32'h0);
    checkOutput("rst_count", count, 32'h0);
    checkOutput("rst_ovf", ovf, 32'h0);
    checkOutput("rst_udf", udf, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill VC0 with four entries; last unit of each rides with the commit
    for (int e = 0; e < 4; e++) begin
      for (int i = 0; i < 10; i++) begin
        applyStimulus(1'b0, 1'b1, 4'(i), 8'(16 + 16 * e + i), 1'b0, 1'b0, 4'd0, 1'b0);
      end
      applyStimulus(1'b0, 1'b1, 4'd10, 8'(16 + 16 * e + 10), 1'b1, 1'b0, 4'd0, 1'b0);
      checkOutput($sformatf("fill_count_e%0d", e), cnt0, e + 1);
      checkOutput($sformatf("fill_afull_e%0d", e), afull[0], (e >= 2));
    end
    checkOutput("fill_wfull", wfull, 32'h1);
    checkOutput("fill_rempty_vc1", rempty[1], 32'h1);
    checkOutput("fill_count_vc1", cnt1, 32'h0);

    // Overflow: rejected commit and rejected unit write each pulse ovf once
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0);
    checkOutput("ovf_commit_pulse", ovf, 32'h1);
    checkOutput("ovf_commit_count", cnt0, 32'h4);
    idleCycle();
    checkOutput("ovf_commit_clear", ovf, 32'h0);
    applyStimulus(1'b0, 1'b1, 4'd0, 8'hEE, 1'b0, 1'b0, 4'd0, 1'b0);
    checkOutput("ovf_write_pulse", ovf, 32'h1);
    idleCycle();
    checkOutput("ovf_write_clear", ovf, 32'h0);
    checkOutput("ovf_write_count", cnt0, 32'h4);

    // Ordered read of all four entries; pop rides with the last unit read
    for (int e = 0; e < 4; e++) begin
      for (int i = 0; i < 11; i++) begin
        applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'(i), (i == 10));
        checkOutput($sformatf("read_e%0d_u%0d", e, i), rdata, 32'(16 + 16 * e + i));
      end
      checkOutput($sformatf("read_count_e%0d", e), cnt0, 3 - e);
    end
    checkOutput("read_rempty", rempty, 32'h3);
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1);
    checkOutput("udf_pulse", udf, 32'h1);
    idleCycle();
    checkOutput("udf_clear", udf, 32'h0);

    // Out-of-range unit addresses: read gives 0, write is silently dropped
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd12, 1'b0);
    checkOutput("raddr_oob", rdata, 32'h0);
    applyStimulus(1'b0, 1'b1, 4'd13, 8'h55, 1'b0, 1'b0, 4'd0, 1'b0);
    checkOutput("waddr_oob_ovf", ovf, 32'h0);
    checkOutput("waddr_oob_count", cnt0, 32'h0);

    // Simultaneous commit and pop on VC1 with two entries held
    applyStimulus(1'b1, 1'b1, 4'd0, 8'hA0, 1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'd1, 8'hA1, 1'b1, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'd0, 8'hB0, 1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'd1, 8'hB1, 1'b1, 1'b0, 4'd0, 1'b0);
    checkOutput("sim_count_before", cnt1, 32'h2);
    applyStimulus(1'b1, 1'b1, 4'd0, 8'hC0, 1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'd1, 8'hC1, 1'b1, 1'b1, 4'd0, 1'b1);
    checkOutput("sim_read_old_head", rdata, 32'hA0);
    checkOutput("sim_count_after", cnt1, 32'h2);
    checkOutput("sim_ovf", ovf, 32'h0);
    checkOutput("sim_udf", udf, 32'h0);
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0);
    checkOutput("sim_new_head_u0", rdata, 32'hB0);
    // VC0 write+commit while VC1 pops in the same cycle
    applyStimulus(1'b0, 1'b1, 4'd0, 8'hD0, 1'b1, 1'b1, 4'd1, 1'b1);
    checkOutput("sim_head_u1", rdata, 32'hB1);
    checkOutput("sim_vc1_count", cnt1, 32'h1);
    checkOutput("sim_vc0_count", cnt0, 32'h1);
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0);
    checkOutput("sim_tail_u0", rdata, 32'hC0);
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd1, 1'b1);
    checkOutput("sim_tail_u1", rdata, 32'hC1);
    checkOutput("sim_rempty_vc1", rempty, 32'h2);
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1);
    checkOutput("sim_vc0_data", rdata, 32'hD0);
    checkOutput("sim_rempty_all", rempty, 32'h3);

    // Pointer wrap: 20 commit/pop pairs on VC0
    for (int n = 0; n < 20; n++) begin
      applyStimulus(1'b0, 1'b1, 4'd0, 8'(64 + n), 1'b1, 1'b0, 4'd0, 1'b0);
      checkOutput($sformatf("wrap_wfull_%0d", n), wfull, 32'h0);
      checkOutput($sformatf("wrap_count_%0d", n), cnt0, 32'h1);
      applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1);
      checkOutput($sformatf("wrap_data_%0d", n), rdata, 32'(64 + n));
    end

    // Reset mid-operation with two entries held
    applyStimulus(1'b0, 1'b1, 4'd0, 8'h77, 1'b1, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd0, 8'h78, 1'b1, 1'b0, 4'd0, 1'b0);
    checkOutput("mid_count_before", cnt0, 32'h2);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_count", count, 32'h0);
    checkOutput("mid_rst_rempty", rempty, 32'h3);
    checkOutput("mid_rst_rdata", rdata, 32'h0);
    checkOutput("mid_rst_afull", afull, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("mid_rst_hold_count", count, 32'h0);
    checkOutput("mid_rst_hold_rdata", rdata, 32'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 4'd0, 8'h99, 1'b1, 1'b0, 4'd0, 1'b0);
    checkOutput("post_rst_count", cnt0, 32'h1);
    checkOutput("post_rst_rempty", rempty, 32'h2);
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1);
    checkOutput("post_rst_data", rdata, 32'h99);
    checkOutput("post_rst_empty", rempty, 32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
